// File: rtl/lcd_ctrl_param_if.sv
// Bus bundle of the LCD image controller: host command strobe, image ROM
// read port and display RAM write port. The controller sits on the slave
// modport; the environment (host + memories) drives the master modport.
interface lcd_ctrl_param_if #(
  parameter int AW    = 6,
  parameter int PIX_W = 8
) ();

  logic [3:0]       cmd;
  logic             cmd_valid;
  logic             IROM_rd;
  logic [AW-1:0]    IROM_A;
  logic [PIX_W-1:0] IROM_Q;
  logic             IRAM_ceb;
  logic             IRAM_web;
  logic [AW-1:0]    IRAM_A;
  logic [PIX_W-1:0] IRAM_D;
  logic             busy;
  logic             done;

  modport slave (
    input  cmd, cmd_valid, IROM_Q,
    output IROM_rd, IROM_A, IRAM_ceb, IRAM_web, IRAM_A, IRAM_D, busy, done
  );

  modport master (
    output cmd, cmd_valid, IROM_Q,
    input  IROM_rd, IROM_A, IRAM_ceb, IRAM_web, IRAM_A, IRAM_D, busy, done
  );

endinterface

// File: rtl/lcd_ctrl_param.sv
// Parametrised LCD image controller.
// Loads an IMG_W x IMG_H image from IROM into a pixel buffer, applies host
// commands to a WIN x WIN window around a movable operation point (shift,
// max, min, average, horizontal and vertical mirror) and streams the whole
// buffer to IRAM on request, pulsing done after the last write.
module lcd_ctrl_param #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int PIX_W = 8,
  parameter int WIN   = 4
) (
  input  logic             clk,
  input  logic             rst,
  lcd_ctrl_param_if.slave  bus
);

  localparam int N   = IMG_W * IMG_H;
  localparam int AW  = $clog2(N);
  localparam int XB  = $clog2(IMG_W);
  localparam int YB  = $clog2(IMG_H);
  localparam int CW  = ((XB > YB) ? XB : YB) + 1;
  localparam int WB  = $clog2(WIN);
  localparam int WN  = WIN * WIN;
  localparam int SW  = PIX_W + 2 * WB;

  localparam logic [AW-1:0] LAST_A = AW'(N - 1);
  localparam logic [AW-1:0] ONE_A  = AW'(1);
  localparam logic [CW-1:0] ONE_C  = CW'(1);
  localparam logic [CW-1:0] HALF_C = CW'(WIN / 2);
  localparam logic [CW-1:0] X_MAX  = CW'(IMG_W - WIN / 2);
  localparam logic [CW-1:0] Y_MAX  = CW'(IMG_H - WIN / 2);
  localparam logic [CW-1:0] X_RST  = CW'(IMG_W / 2);
  localparam logic [CW-1:0] Y_RST  = CW'(IMG_H / 2);

  typedef enum logic [2:0] {
    S_LOAD  = 3'd0,
    S_IDLE  = 3'd1,
    S_EXEC  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           state_r;
  logic [3:0]       cmd_r;
  logic [CW-1:0]    op_x_r;
  logic [CW-1:0]    op_y_r;

  logic             irom_rd_r;
  logic [AW-1:0]    irom_a_r;
  logic             rom_pend_r;
  logic [AW-1:0]    cap_a_r;

  logic             iram_ceb_r;
  logic             iram_web_r;
  logic [AW-1:0]    iram_a_r;
  logic [PIX_W-1:0] iram_d_r;
  logic             busy_r;
  logic             done_r;

  logic [PIX_W-1:0] buf_r     [N];
  logic [PIX_W-1:0] buf_nxt_s [N];

  logic [CW-1:0]    win_x0_s;
  logic [CW-1:0]    win_y0_s;
  logic [CW-1:0]    win_xx_s;
  logic [CW-1:0]    win_yy_s;
  logic [AW-1:0]    win_a_s   [WN];
  logic [PIX_W-1:0] win_p_s   [WN];
  logic [PIX_W-1:0] win_max_s;
  logic [PIX_W-1:0] win_min_s;
  logic [PIX_W-1:0] win_avg_s;
  logic [SW-1:0]    win_sum_s;

  assign bus.IROM_rd  = irom_rd_r;
  assign bus.IROM_A   = irom_a_r;
  assign bus.IRAM_ceb = iram_ceb_r;
  assign bus.IRAM_web = iram_web_r;
  assign bus.IRAM_A   = iram_a_r;
  assign bus.IRAM_D   = iram_d_r;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;

  // Window geometry: raster address and current value of every window pixel.
  always_comb begin
    win_x0_s = op_x_r - HALF_C;
    win_y0_s = op_y_r - HALF_C;
    win_xx_s = '0;
    win_yy_s = '0;
    win_a_s  = '{default: '0};
    win_p_s  = '{default: '0};
    for (int r = 0; r < WIN; r++) begin
      for (int c = 0; c < WIN; c++) begin
        win_yy_s = win_y0_s + CW'(r);
        win_xx_s = win_x0_s + CW'(c);
        // Power-of-two width makes y*IMG_W + x a plain concatenation.
        win_a_s[r*WIN + c] = {win_yy_s[YB-1:0], win_xx_s[XB-1:0]};
        win_p_s[r*WIN + c] = buf_r[{win_yy_s[YB-1:0], win_xx_s[XB-1:0]}];
      end
    end
  end

  // Window statistics: max, min and floor average over all window pixels.
  always_comb begin
    win_max_s = win_p_s[0];
    win_min_s = win_p_s[0];
    win_sum_s = '0;
    win_avg_s = '0;
    for (int i = 0; i < WN; i++) begin
      win_max_s = (win_p_s[i] > win_max_s) ? win_p_s[i] : win_max_s;
      win_min_s = (win_p_s[i] < win_min_s) ? win_p_s[i] : win_min_s;
      win_sum_s = win_sum_s + SW'(win_p_s[i]);
    end
    // WIN*WIN is a power of two, so the divide is a right shift.
    win_avg_s = PIX_W'(win_sum_s >> (2 * WB));
  end

  // Next buffer contents: ROM capture during load, window rewrite in exec.
  // Every window result reads buf_r, so all updates use pre-command values.
  always_comb begin
    buf_nxt_s = buf_r;
    if (state_r == S_LOAD && rom_pend_r) begin
      buf_nxt_s[cap_a_r] = bus.IROM_Q;
    end else if (state_r == S_EXEC) begin
      case (cmd_r)
        4'd5: begin
          for (int i = 0; i < WN; i++) buf_nxt_s[win_a_s[i]] = win_max_s;
        end
        4'd6: begin
          for (int i = 0; i < WN; i++) buf_nxt_s[win_a_s[i]] = win_min_s;
        end
        4'd7: begin
          for (int i = 0; i < WN; i++) buf_nxt_s[win_a_s[i]] = win_avg_s;
        end
        4'd8: begin
          for (int r = 0; r < WIN; r++) begin
            for (int c = 0; c < WIN; c++) begin
              buf_nxt_s[win_a_s[r*WIN + c]] = win_p_s[r*WIN + (WIN - 1 - c)];
            end
          end
        end
        4'd9: begin
          for (int r = 0; r < WIN; r++) begin
            for (int c = 0; c < WIN; c++) begin
              buf_nxt_s[win_a_s[r*WIN + c]] = win_p_s[(WIN - 1 - r)*WIN + c];
            end
          end
        end
        default: buf_nxt_s = buf_r;
      endcase
    end else begin
      buf_nxt_s = buf_r;
    end
  end

  // Pixel buffer storage; contents are undefined after reset until reloaded.
  always_ff @(posedge clk) begin
    buf_r <= buf_nxt_s;
  end

  // Control FSM with registered memory-port and handshake outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= S_LOAD;
      cmd_r      <= 4'd0;
      op_x_r     <= X_RST;
      op_y_r     <= Y_RST;
      irom_rd_r  <= 1'b0;
      irom_a_r   <= '0;
      rom_pend_r <= 1'b0;
      cap_a_r    <= '0;
      iram_ceb_r <= 1'b0;
      iram_web_r <= 1'b1;
      iram_a_r   <= '0;
      iram_d_r   <= '0;
      busy_r     <= 1'b1;
      done_r     <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        S_LOAD: begin
          // ROM data returns one cycle after the read; remember which
          // address is in flight so the capture lands in the right slot.
          rom_pend_r <= irom_rd_r;
          cap_a_r    <= irom_a_r;
          if (!irom_rd_r && !rom_pend_r) begin
            irom_rd_r <= 1'b1;
            irom_a_r  <= '0;
          end else if (irom_rd_r) begin
            if (irom_a_r == LAST_A) begin
              irom_rd_r <= 1'b0;
            end else begin
              irom_a_r <= irom_a_r + ONE_A;
            end
          end
          if (rom_pend_r && cap_a_r == LAST_A) begin
            state_r <= S_IDLE;
            busy_r  <= 1'b0;
          end
        end
        S_IDLE: begin
          if (bus.cmd_valid) begin
            cmd_r  <= bus.cmd;
            busy_r <= 1'b1;
            if (bus.cmd == 4'd0) begin
              state_r    <= S_WRITE;
              iram_ceb_r <= 1'b1;
              iram_web_r <= 1'b0;
              iram_a_r   <= '0;
              iram_d_r   <= buf_r[0];
            end else begin
              state_r <= S_EXEC;
            end
          end
        end
        S_EXEC: begin
          state_r <= S_IDLE;
          busy_r  <= 1'b0;
          case (cmd_r)
            4'd1: if (op_y_r > HALF_C) op_y_r <= op_y_r - ONE_C;
            4'd2: if (op_y_r < Y_MAX)  op_y_r <= op_y_r + ONE_C;
            4'd3: if (op_x_r > HALF_C) op_x_r <= op_x_r - ONE_C;
            4'd4: if (op_x_r < X_MAX)  op_x_r <= op_x_r + ONE_C;
            default: begin
            end
          endcase
        end
        S_WRITE: begin
          if (iram_a_r == LAST_A) begin
            iram_ceb_r <= 1'b0;
            iram_web_r <= 1'b1;
            state_r    <= S_DONE;
            done_r     <= 1'b1;
          end else begin
            iram_a_r <= iram_a_r + ONE_A;
            iram_d_r <= buf_r[iram_a_r + ONE_A];
          end
        end
        S_DONE: begin
          state_r <= S_IDLE;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r    <= S_LOAD;
          irom_rd_r  <= 1'b0;
          irom_a_r   <= '0;
          rom_pend_r <= 1'b0;
          iram_ceb_r <= 1'b0;
          iram_web_r <= 1'b1;
          busy_r     <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/lcd_ctrl_param.md
Name: lcd_ctrl_param

Overview:
- Parametrised next-generation LCD image controller.
- Loads an IMG_W x IMG_H image from IROM into an internal pixel buffer.
- Applies host commands to a WIN x WIN window at a movable operation point: shift, max, min, average, plus new horizontal/vertical mirror modes.
- Writes the whole buffer to IRAM on command and pulses done. It sits between the image ROM, the host command interface and the display RAM.

Parameters:
IMG_W, 8, image width in pixels (power of 2, >= WIN)
IMG_H, 8, image height in pixels (power of 2, >= WIN)
PIX_W, 8, bits per pixel
WIN, 4, window edge length (power of 2, >= 2)
AW, log2(IMG_W*IMG_H), ROM/RAM address width (derived, not overridden)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-low
cmd  in  4  command code
cmd_valid  in  1  command strobe, sampled only while busy=0
IROM_rd  out  1  ROM read enable
IROM_A  out  AW  ROM address
IROM_Q  in  PIX_W  ROM data, valid the cycle after IROM_A is presented with IROM_rd=1
IRAM_ceb  out  1  RAM chip enable, high during writes
IRAM_web  out  1  RAM write select, 0=write, 1=read
IRAM_A  out  AW  RAM address
IRAM_D  out  PIX_W  RAM write data
busy  out  1  high while the block is not accepting commands
done  out  1  one-cycle pulse after the final IRAM write

Behaviour:
- Reset (rst low, async):
  - State=LOAD. busy=1, done=0, IROM_rd=0, IROM_A=0.
  - IRAM_ceb=0, IRAM_web=1, IRAM_A=0, IRAM_D=0.
  - op_x=IMG_W/2, op_y=IMG_H/2. Buffer contents are undefined.
- Raster addressing: addr = y*IMG_W + x.
- Window extent: rows op_y-WIN/2..op_y+WIN/2-1, cols op_x-WIN/2..op_x+WIN/2-1.
- op legal range: op_x in [WIN/2, IMG_W-WIN/2], op_y in [WIN/2, IMG_H-WIN/2].
- States: LOAD, IDLE, EXEC, WRITE, DONE.
- LOAD:
  - IROM_rd=1. IROM_A steps 0..N-1 (N=IMG_W*IMG_H), one per cycle.
  - IROM_Q is captured into buffer[A-1] one cycle late.
  - After the last capture (N+1 cycles after rst release), IROM_rd=0 and the block enters IDLE.
- IDLE:
  - busy=0.
  - When cmd_valid=1, cmd is latched and busy rises the next cycle.
  - cmd=0 goes to WRITE. Any other code goes to EXEC.
- EXEC (exactly 1 cycle), then IDLE:
  - 1 up: op_y-1, saturates at the lower bound.
  - 2 down: op_y+1, saturates at the upper bound.
  - 3 left: op_x-1, saturates.
  - 4 right: op_x+1, saturates.
  - 5 max: every window pixel becomes the window maximum.
  - 6 min: every window pixel becomes the window minimum.
  - 7 avg: every window pixel becomes floor(sum/(WIN*WIN)). Sum width is PIX_W+2*log2(WIN), with no overflow.
  - 8 mirror-x: within each window row, pixel at column offset k swaps with offset WIN-1-k.
  - 9 mirror-y: within each window column, row offset k swaps with offset WIN-1-k.
  - 10-15: no-op. Still 1 cycle busy.
  - All window updates are computed from pre-command values (simultaneous update).
- WRITE:
  - IRAM_ceb=1, IRAM_web=0.
  - IRAM_A steps 0..N-1, one per cycle, with IRAM_D=buffer[IRAM_A] registered alongside.
  - N cycles, then DONE.
- DONE: done=1 for one cycle, busy=1, then IDLE.
  - The buffer and op point are retained.
  - Further commands, including another write, are legal.
- Outside WRITE: IRAM_ceb=0, IRAM_web=1.
- Outside LOAD: IROM_rd=0.
- cmd_valid while busy=1 is ignored and not queued.
- Reset asserted mid-LOAD, mid-EXEC or mid-WRITE:
  - Immediate abort to the reset values above.
  - A partial IRAM write is not completed.
  - A full reload follows reset release.

Test Plan:
- Default params, ROM[a]=a, release reset:
  - IROM_A sweeps 0..63 with IROM_rd=1.
  - busy falls at cycle 65.
  - cmd 0 then writes IRAM[a]=a for a=0..63 in order.
  - done pulses once, 1 cycle after IRAM_A=63.
- Same image:
  - cmd 5 then cmd 0 -> IRAM rows 2..5, cols 2..5 = 45; other addresses unchanged.
  - After reset, cmd 6 -> window = 18.
  - After reset, cmd 7 -> window = 31.
- Five cmd 1 from reset, then cmd 5 -> op_y clamps at 2; window rows 0..3, cols 2..5 = 29 (max).
- Five cmd 4 then five cmd 3 -> op_x saturates at 6, then at 2; no wrap.
- cmd 8 at reset point -> row 2 cols 2..5 reads 21,20,19,18.
- cmd 9 -> col 2 rows 2..5 reads 42,34,26,18.
- Reset mid-write:
  - Pull rst low at IRAM_A=20 -> IRAM_ceb=0, busy=1, IROM_A=0 asynchronously.
  - After release, reload completes and done never pulses for the aborted write.
- Params IMG_W=16, IMG_H=8, WIN=2 -> reset op=(8,4); cmd 7 averages pixels (3..4, 7..8) = floor(sum/4); write covers 128 addresses.
